// File: rtl/psram_qpi_pkg.sv
// Shared types and constants for the QPI PSRAM engine.
package psram_qpi_pkg;
  localparam int ADDR_WIDTH = 24;
  localparam int DATA_WIDTH = 32;
  localparam int NIB_W      = 4;                          // period counter, covers up to 15 dummies
  localparam int FRAME_W    = 8 + ADDR_WIDTH + DATA_WIDTH; // cmd + addr + data bits on the wire

  localparam logic [7:0] CMD_QWR = 8'h38;
  localparam logic [7:0] CMD_QRD = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_CEH
  } state_e;

  // Word <-> wire order: byte 0 travels first, so the word is byte-reversed.
  function automatic logic [DATA_WIDTH-1:0] bswap32(input logic [DATA_WIDTH-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/psram_sck_gen.sv
// SCK half-period timer: counts 0..div per half, flips phase on terminal count.
module psram_sck_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [7:0] div_i,
  output logic       tick_o,
  output logic       phase_o
);
  logic [7:0] cnt_q, cnt_d;
  logic       ph_q, ph_d;

  assign tick_o  = run_i && (cnt_q == div_i);
  assign phase_o = ph_q;

  // Hold at the start of a low half while idle so every frame starts aligned.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (!run_i) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (tick_o) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end
endmodule

// File: rtl/psram_qpi_engine.sv
// QPI frame sequencer: cmd / addr / dummy / data serialiser and read deserialiser.
module psram_qpi_engine
  import psram_qpi_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            cfg_clkdiv_i,
  input  logic [3:0]            cfg_dummy_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  busy_o,
  output logic                  psram_sck_o,
  output logic                  psram_ce_n_o,
  output logic [3:0]            psram_io_out_o,
  output logic [3:0]            psram_io_en_o,
  input  logic [3:0]            psram_io_in_i
);
  state_e                state_q, state_d;
  logic [NIB_W-1:0]      nib_q, nib_d, nib_lim;
  logic [7:0]            div_q, div_d;
  logic [3:0]            dummy_q, dummy_d;
  logic                  we_q, we_d;
  logic [FRAME_W-1:0]    tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rdata_q, rdata_d;
  logic                  rd_last_q, rd_last_d, rsp_valid_q, rsp_valid_d;
  logic                  tick, phase, tick_lo, tick_hi, active, drive, nib_last;

  assign active  = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA};
  assign drive   = state_q inside {S_CMD, S_ADDR, S_WDATA};
  assign tick_lo = tick & ~phase;
  assign tick_hi = tick & phase;

  psram_sck_gen u_sck (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (state_q != S_IDLE),
    .div_i   (div_q),
    .tick_o  (tick),
    .phase_o (phase)
  );

  // Outputs decode straight from flops, so reset clears them without a clock.
  assign psram_sck_o    = phase & active;
  assign psram_ce_n_o   = ~active;
  assign psram_io_en_o  = drive ? 4'hF : 4'h0;
  assign psram_io_out_o = drive ? tx_q[FRAME_W-1 -: 4] : 4'h0;
  assign req_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;

  // Last SCK period index of the current state.
  always_comb begin
    nib_lim = '0;
    case (state_q)
      S_CMD:            nib_lim = NIB_W'(1);
      S_ADDR:           nib_lim = NIB_W'(5);
      S_DUMMY:          nib_lim = dummy_q - NIB_W'(1);
      S_WDATA, S_RDATA: nib_lim = NIB_W'(7);
      default:          nib_lim = '0;
    endcase
  end

  // Next-state, shifters and response; state advances at the end of a high half.
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    div_d       = div_q;
    dummy_d     = dummy_q;
    we_d        = we_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_last_d   = 1'b0;
    rsp_valid_d = rd_last_q;
    rdata_d     = rd_last_q ? bswap32(rx_q) : rdata_q;
    nib_last    = (nib_q == nib_lim);
    if (state_q == S_IDLE) begin
      if (req_valid_i) begin
        state_d = S_CMD;
        nib_d   = '0;
        div_d   = cfg_clkdiv_i;
        dummy_d = (cfg_dummy_i == 4'd0) ? 4'd1 : cfg_dummy_i;
        we_d    = req_we_i;
        tx_d    = {(req_we_i ? CMD_QWR : CMD_QRD), req_addr_i, bswap32(req_wdata_i)};
      end
    end else begin
      if (tick_lo && state_q == S_RDATA) rx_d = {rx_q[DATA_WIDTH-5:0], psram_io_in_i};
      if (tick_hi) begin
        nib_d = nib_last ? '0 : nib_q + NIB_W'(1);
        if (drive) tx_d = {tx_q[FRAME_W-5:0], 4'h0};
        if (nib_last) begin
          case (state_q)
            S_CMD:   state_d = S_ADDR;
            S_ADDR:  state_d = we_q ? S_WDATA : S_DUMMY;
            S_DUMMY: state_d = S_RDATA;
            S_WDATA: state_d = S_CEH;
            S_RDATA: begin
              state_d   = S_CEH;
              rd_last_d = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      nib_q       <= '0;
      div_q       <= '0;
      dummy_q     <= 4'd1;
      we_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_last_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      div_q       <= div_d;
      dummy_q     <= dummy_d;
      we_q        <= we_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_last_q   <= rd_last_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_psram_qpi_engine.sv
// Directed + table-driven bench with a wire-level PSRAM model.
module tb_psram_qpi_engine;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  cfg_div = 8'd0;
  logic [3:0]  cfg_dm = 4'd0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, busy, sck, ce_n;
  logic [31:0] rsp_rdata;
  logic [3:0]  io_out, io_en, io_in = 4'h0;

  psram_qpi_engine dut (
    .clk_i(clk), .rst_i(rst), .cfg_clkdiv_i(cfg_div), .cfg_dummy_i(cfg_dm),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .busy_o(busy), .psram_sck_o(sck), .psram_ce_n_o(ce_n),
    .psram_io_out_o(io_out), .psram_io_en_o(io_en), .psram_io_in_i(io_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int i);
    logic [7:0] b;
    b = w[8*(i/2) +: 8];
    return (i % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [31:0] wire_of(input logic [31:0] w);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[27:0], nib_of(w, i)};
    return r;
  endfunction

  // ---------------- PSRAM device model (observes pins on negedge) ----------------
  logic [31:0] mem [logic [23:0]];
  int          mk = 0, low_cnt = 0, hi_cnt = 0, last_low = 0, last_gap = 0;
  int          frames = 0, rsp_cnt = 0, age = 0, rsp_age = 0, cur_dm = 1, idx;
  logic [31:0] hdr = '0, wn = '0, last_hdr = '0, last_wn = '0, last_rsp = '0, rdw;
  logic        en_ok = 1'b1, last_en_ok = 1'b1, sck_p = 1'b0, ce_p = 1'b1, m_rd = 1'b0;

  // Decode frames, drive read nibbles during low halves, log response pulses.
  always @(negedge clk) begin
    if (!ce_n) begin
      if (ce_p) begin
        mk = 0; low_cnt = 0; hdr = '0; wn = '0; en_ok = 1'b1; m_rd = 1'b0; last_gap = hi_cnt;
      end
      low_cnt++;
      if (sck && !sck_p) begin
        if (mk < 8) begin
          hdr = {hdr[27:0], io_out};
          if (io_en != 4'hF) en_ok = 1'b0;
        end else if (!m_rd) begin
          if (mk < 16) wn = {wn[27:0], io_out};
          if (io_en != 4'hF) en_ok = 1'b0;
        end else if (io_en != 4'h0) en_ok = 1'b0;
        mk++;
        if (mk == 2) m_rd = (hdr[7:0] == 8'hEB);
      end
      if (!sck && sck_p && m_rd) begin
        if (mk == 8 && io_en != 4'h0) en_ok = 1'b0;
        idx = mk - 8 - cur_dm;
        rdw = mem.exists(hdr[23:0]) ? mem[hdr[23:0]] : 32'h0;
        if (idx >= 0 && idx < 8) io_in = nib_of(rdw, idx);
      end
      age++;
      hi_cnt = 0;
    end else begin
      if (!ce_p) begin
        frames++; last_low = low_cnt; last_hdr = hdr; last_wn = wn; last_en_ok = en_ok;
        age = 0; hi_cnt = 1;
        if (!m_rd && mk == 16) mem[hdr[23:0]] = {wn[7:0], wn[15:8], wn[23:16], wn[31:24]};
      end else begin
        age++; hi_cnt++;
      end
    end
    if (rsp_valid) begin rsp_cnt++; last_rsp = rsp_rdata; rsp_age = age; end
    sck_p = sck; ce_p = ce_n;
  end

  // ---------------- transaction driver ----------------
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [7:0]  div;
    logic [3:0]  dm;
    logic        chg;       // change cfg right after acceptance
    int          exp_low;   // clk cycles with ce_n low
    logic [31:0] exp_hdr;   // cmd byte + address as seen on the wire
    logic [31:0] exp_data;  // write: wire nibble order; read: response word
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int t, f0, r0;
    @(negedge clk);
    cfg_div = v.div; cfg_dm = v.dm; cur_dm = (v.dm == 0) ? 1 : int'(v.dm);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 1000) begin @(negedge clk); t++; end
    chk({tag, "_accept_to"}, (t >= 1000), 0);
    f0 = frames; r0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.chg) begin cfg_div = 8'd3; cfg_dm = 4'd5; end
    t = 0;
    while (busy && t < 4000) begin @(negedge clk); t++; end
    chk({tag, "_busy_to"}, (t >= 4000), 0);
    @(negedge clk);
    chk({tag, "_frames"}, frames, f0 + 1);
    chk({tag, "_ce_low"}, last_low, v.exp_low);
    chk({tag, "_hdr"}, last_hdr, v.exp_hdr);
    chk({tag, "_io_en"}, last_en_ok, 1);
    if (v.we) begin
      chk({tag, "_wnib"}, last_wn, v.exp_data);
      chk({tag, "_no_rsp"}, rsp_cnt, r0);
    end else begin
      chk({tag, "_rsp_cnt"}, rsp_cnt, r0 + 1);
      chk({tag, "_rdata"}, last_rsp, v.exp_data);
      chk({tag, "_rsp_age"}, rsp_age, 1);
    end
  endtask

  vec_t vecs[8];
  vec_t rv;
  logic [31:0] sb [logic [23:0]];
  logic [23:0] pool [4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, f0, r0, bad, d;
    mem[24'h000100] = 32'h11223344;
    //          we    addr         wdata         div   dm    chg  low  hdr           data
    vecs[0] = '{1'b1, 24'h123456, 32'hAABBCCDD, 8'd0, 4'd0, 1'b0, 32, 32'h38123456, 32'hDDCCBBAA};
    vecs[1] = '{1'b0, 24'h000100, 32'h0,        8'd1, 4'd6, 1'b0, 88, 32'hEB000100, 32'h11223344};
    vecs[2] = '{1'b0, 24'h123456, 32'h0,        8'd0, 4'd0, 1'b0, 34, 32'hEB123456, 32'hAABBCCDD};
    vecs[3] = '{1'b1, 24'hABCDEF, 32'h01234567, 8'd3, 4'd9, 1'b0, 128, 32'h38ABCDEF, 32'h67452301};
    vecs[4] = '{1'b0, 24'hABCDEF, 32'h0,        8'd2, 4'd3, 1'b0, 114, 32'hEBABCDEF, 32'h01234567};
    vecs[5] = '{1'b0, 24'h123456, 32'h0,        8'd1, 4'd0, 1'b1, 68, 32'hEB123456, 32'hAABBCCDD};
    vecs[6] = '{1'b1, 24'h000000, 32'hDEADBEEF, 8'd1, 4'd2, 1'b0, 64, 32'h38000000, 32'hEFBEADDE};
    vecs[7] = '{1'b0, 24'h000000, 32'h0,        8'd0, 4'd15, 1'b0, 62, 32'hEB000000, 32'hDEADBEEF};

    // reset values, sampled while reset is held
    #1;
    chk("rst_pins", {sck, ce_n, io_out, io_en}, {1'b0, 1'b1, 4'h0, 4'h0});
    chk("rst_ctrl", {req_ready, rsp_valid, busy}, {1'b1, 1'b0, 1'b0});
    chk("rst_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // back-to-back reads with valid held high
    @(negedge clk);
    cfg_div = 8'd1; cfg_dm = 4'd2; cur_dm = 2;
    req_we = 1'b0; req_addr = 24'h000100; req_valid = 1'b1;
    f0 = frames; r0 = rsp_cnt;
    @(negedge clk);
    bad = 0; t = 0;
    while (frames == f0 && t < 1000) begin
      if (req_ready || !busy) bad++;
      @(negedge clk); t++;
    end
    chk("b2b_hold", bad, 0);
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (busy && t < 1000) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("b2b_frames", frames, f0 + 2);
    chk("b2b_rsp", rsp_cnt, r0 + 2);
    chk("b2b_rdata", last_rsp, 32'h11223344);
    chk("b2b_gap", last_gap, 5);

    // reset during ADDR of a read
    @(negedge clk);
    cfg_div = 8'd2; cfg_dm = 4'd4; cur_dm = 4;
    req_we = 1'b0; req_addr = 24'h000100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (mk < 3 && t < 200) begin @(negedge clk); t++; end
    chk("rstmid_reach_addr", (mk >= 3 && !ce_n), 1);
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_pins", {ce_n, io_en, sck}, {1'b1, 4'h0, 1'b0});
    chk("rstmid_ctrl", {req_ready, busy}, {1'b1, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid_no_rsp", rsp_cnt, r0);
    rv = '{1'b1, 24'h000200, 32'hCAFEF00D, 8'd1, 4'd0, 1'b0, 64, 32'h38000200, 32'h0DF0FECA};
    run_txn(rv, "post_rst_w");
    rv = '{1'b0, 24'h000200, 32'h0, 8'd0, 4'd1, 1'b0, 34, 32'hEB000200, 32'hCAFEF00D};
    run_txn(rv, "post_rst_r");

    // random read-after-write stream
    pool[0] = 24'h000010; pool[1] = 24'h7FFFFC; pool[2] = 24'h00ABCD; pool[3] = 24'hFFFFFF;
    for (int n = 0; n < 28; n++) begin
      rv.addr  = pool[(n < 4) ? n : $urandom_range(0, 3)];
      rv.we    = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      rv.wdata = $urandom;
      rv.div   = 8'($urandom_range(0, 3));
      rv.dm    = 4'($urandom_range(0, 15));
      rv.chg   = 1'b0;
      d        = rv.we ? 0 : ((rv.dm == 0) ? 1 : int'(rv.dm));
      rv.exp_low = (16 + d) * 2 * (int'(rv.div) + 1);
      rv.exp_hdr = {(rv.we ? 8'h38 : 8'hEB), rv.addr};
      if (rv.we) begin
        rv.exp_data = wire_of(rv.wdata);
        sb[rv.addr] = rv.wdata;
      end else begin
        rv.exp_data = sb[rv.addr];
      end
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
